// File: rtl/palette_arbiter.sv
// rtl/palette_arbiter.sv - palette RAM port arbiter between display scan and host
//
// Shares one palette RAM port between the display pattern generator, which
// owns it whenever vActive=1, and a single outstanding host read/write that
// is slipped in on a vActive=0 cycle.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   vActive, disp_addr    display scan ownership flag and palette index
//   host_req/wr/addr/wdata  host request, sampled only while idle
//   host_busy, host_done  request outstanding / one-cycle completion pulse
//   host_rdata            result of the last host read
//   defer_cnt, defer_clr  saturating count of cycles a host access waited
//   ram_addr/data/wren    palette RAM port
//   ram_q                 palette RAM read data, one cycle after the address
module palette_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vActive,
   input  logic [ADDR_W-1:0] disp_addr,
   input  logic              host_req,
   input  logic              host_wr,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_busy,
   output logic              host_done,
   output logic [DATA_W-1:0] host_rdata,
   output logic [15:0]       defer_cnt,
   input  logic              defer_clr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q
);

   typedef enum logic [1:0] {IDLE, PEND, CAPT, DONE} state_t;

   state_t            state;
   logic              lat_wr;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_data;
   logic              grant;

   // The host gets the port only in a pending cycle the display leaves free;
   // reset blocks the grant so an abandoned write never reaches the RAM.
   assign grant    = (state == PEND) && !vActive && !reset;
   assign ram_addr = grant ? lat_addr : disp_addr;
   assign ram_data = lat_data;
   assign ram_wren = grant && lat_wr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         host_busy  <= 1'b0;
         host_done  <= 1'b0;
         host_rdata <= '0;
         defer_cnt  <= '0;
         lat_wr     <= 1'b0;
         lat_addr   <= '0;
         lat_data   <= '0;
      end else begin
         host_done <= 1'b0;

         // Clear has priority over a deferral in the same cycle.
         if (defer_clr)
            defer_cnt <= '0;
         else if (state == PEND && vActive && defer_cnt != 16'hFFFF)
            defer_cnt <= defer_cnt + 16'd1;

         unique case (state)
            IDLE: begin
               if (host_req) begin
                  lat_wr    <= host_wr;
                  lat_addr  <= host_addr;
                  lat_data  <= host_wdata;
                  host_busy <= 1'b1;
                  state     <= PEND;
               end
            end
            PEND: begin
               if (!vActive) begin
                  if (lat_wr) begin
                     state     <= DONE;
                     host_done <= 1'b1;
                  end else begin
                     state <= CAPT;
                  end
               end
            end
            CAPT: begin
               // ram_q now reflects the address driven in the grant cycle,
               // whatever the display is doing this cycle.
               host_rdata <= ram_q;
               host_done  <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               host_busy <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_palette_arbiter.sv
// tb/tb_palette_arbiter.sv - scoreboard bench for palette_arbiter
module tb_palette_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        vActive;
   logic [5:0]  disp_addr;
   logic        host_req;
   logic        host_wr;
   logic [5:0]  host_addr;
   logic [23:0] host_wdata;
   logic        host_busy;
   logic        host_done;
   logic [23:0] host_rdata;
   logic [15:0] defer_cnt;
   logic        defer_clr;
   logic [5:0]  ram_addr;
   logic [23:0] ram_data;
   logic        ram_wren;
   logic [23:0] ram_q;

   palette_arbiter #(.ADDR_W(6), .DATA_W(24)) dut (
      .clk(clk), .reset(reset), .vActive(vActive), .disp_addr(disp_addr),
      .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_busy(host_busy), .host_done(host_done),
      .host_rdata(host_rdata), .defer_cnt(defer_cnt), .defer_clr(defer_clr),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
      .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [5:0]  addr;
      logic [23:0] data;
      logic [23:0] exp_rdata;
      int          req_cyc;
      int          lat;
      logic [15:0] exp_defer;
   } entry_t;

   entry_t      q[$];
   logic [23:0] mem[64];     // behavioural palette RAM
   logic [23:0] shadow[64];  // what the palette should hold
   logic [23:0] last_read;
   int          exp_defer;
   bit          exp_busy;
   bit          mon_en;
   int          cyc;
   int          n_cmp;
   int          n_bad;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_wren) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
      disp_addr <= 6'($urandom);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: per-cycle port rules plus scoreboard pop on every done pulse.
   always @(negedge clk) begin
      if (mon_en) begin
         entry_t e;
         check("host_busy", {31'd0, host_busy}, {31'd0, exp_busy});
         if (vActive) begin
            check("display_wren", {31'd0, ram_wren}, 32'd0);
            check("display_addr", {26'd0, ram_addr}, {26'd0, disp_addr});
         end
         if (ram_wren) begin
            if (q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL stray_wren: ram_wren=1 with no request outstanding (cycle %0d)", cyc);
            end else begin
               check("wren_is_write", {31'd0, ram_wren}, {31'd0, q[0].wr});
               check("wren_addr", {26'd0, ram_addr}, {26'd0, q[0].addr});
               check("wren_data", {8'd0, ram_data}, {8'd0, q[0].data});
            end
         end
         if (host_done) begin
            if (q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL stray_done: host_done=1 with no request outstanding (cycle %0d)", cyc);
            end else begin
               e = q.pop_front();
               check("done_latency", 32'(cyc - e.req_cyc), 32'(e.lat));
               check("host_rdata", {8'd0, host_rdata}, {8'd0, e.exp_rdata});
               check("defer_cnt", {16'd0, defer_cnt}, {16'd0, e.exp_defer});
            end
         end
      end
   end

   // Issue one request in the current cycle; d = cycles the display keeps
   // vActive high, clr_at = deferred cycle (1..d) carrying defer_clr, 0 = none.
   task automatic do_req(input bit wr, input logic [5:0] a, input logic [23:0] dt,
                         input int d, input int clr_at);
      entry_t e;
      int     lat;
      lat = (wr ? 2 : 3) + d;
      host_req = 1'b1; host_wr = wr; host_addr = a; host_wdata = dt;
      vActive = 1'($urandom); defer_clr = 1'b0; exp_busy = 1'b0;
      e.wr = wr; e.addr = a; e.data = dt; e.req_cyc = cyc; e.lat = lat;
      if (wr) begin
         e.exp_rdata = last_read;
         shadow[a] = dt;
      end else begin
         e.exp_rdata = shadow[a];
         last_read = shadow[a];
      end
      if (clr_at > 0) exp_defer = d - clr_at;
      else exp_defer = (exp_defer + d > 65535) ? 65535 : exp_defer + d;
      e.exp_defer = 16'(exp_defer);
      q.push_back(e);
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         // host_req noise while busy (including DONE) must be ignored
         host_req = 1'($urandom); host_wr = 1'($urandom);
         host_addr = 6'($urandom); host_wdata = 24'($urandom);
         exp_busy = 1'b1;
         vActive = (k <= d) ? 1'b1 : (k == d + 1) ? 1'b0 : 1'($urandom);
         defer_clr = (k == clr_at);
      end
      @(posedge clk); #1;
      host_req = 1'b0; exp_busy = 1'b0; vActive = 1'($urandom); defer_clr = 1'b0;
   endtask

   task automatic gap(input bit clr);
      host_req = 1'b0; defer_clr = clr; vActive = 1'($urandom);
      if (clr) exp_defer = 0;
      @(posedge clk); #1;
      defer_clr = 1'b0;
   endtask

   initial begin
      #950000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0; mon_en = 0; exp_busy = 0;
      last_read = '0; exp_defer = 0;
      for (int i = 0; i < 64; i++) begin
         mem[i] = 24'($urandom);
         shadow[i] = mem[i];
      end
      reset = 1'b1; vActive = 1'b0; host_req = 1'b0; host_wr = 1'b0;
      host_addr = '0; host_wdata = '0; defer_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1; reset = 1'b0;
      @(negedge clk);
      check("rst_busy", {31'd0, host_busy}, 32'd0);
      check("rst_done", {31'd0, host_done}, 32'd0);
      check("rst_rdata", {8'd0, host_rdata}, 32'd0);
      check("rst_defer", {16'd0, defer_cnt}, 32'd0);
      check("rst_wren", {31'd0, ram_wren}, 32'd0);
      mon_en = 1;
      @(posedge clk); #1;

      // write then read back address 5 with the display idle
      do_req(1'b1, 6'd5, 24'hFF0000, 0, 0);
      do_req(1'b0, 6'd5, 24'h000000, 0, 0);
      gap(1'b1);
      // 10 deferred cycles
      do_req(1'b0, 6'd9, 24'h0, 10, 0);
      gap(1'b1);
      // saturation: reach FFFE, then 5 more deferrals pin at FFFF
      do_req(1'b1, 6'd12, 24'h123456, 65534, 0);
      do_req(1'b0, 6'd12, 24'h0, 5, 0);
      // clear coinciding with a deferral
      do_req(1'b1, 6'd13, 24'h00FF00, 3, 3);
      do_req(1'b0, 6'd13, 24'h0, 4, 1);

      // reset during the grant cycle of a write: write abandoned, no done
      host_req = 1'b1; host_wr = 1'b1; host_addr = 6'd7; host_wdata = 24'hABCDEF;
      exp_busy = 1'b0;
      @(posedge clk); #1;
      host_req = 1'b0; reset = 1'b1; vActive = 1'b0; exp_busy = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; exp_busy = 1'b0; last_read = '0; exp_defer = 0;
      @(negedge clk);
      check("rst2_rdata", {8'd0, host_rdata}, 32'd0);
      check("rst2_defer", {16'd0, defer_cnt}, 32'd0);
      @(posedge clk); #1;
      // reset beats a simultaneous request
      host_req = 1'b1; host_wr = 1'b1; host_addr = 6'd8; reset = 1'b1;
      @(posedge clk); #1;
      host_req = 1'b0; reset = 1'b0;
      repeat (4) gap(1'b0);
      do_req(1'b0, 6'd7, 24'h0, 0, 0);  // address 7 must be untouched
      do_req(1'b0, 6'd8, 24'h0, 1, 0);

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         int g;
         g = $urandom_range(0, 3);
         for (int j = 0; j < g; j++) gap($urandom_range(0, 7) == 0);
         do_req(1'($urandom), 6'($urandom), 24'($urandom),
                $urandom_range(0, 5), 0);
      end

      repeat (6) gap(1'b0);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
